// File: rtl/cluster_timer_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cluster_timer_arb_pkg
// Description : Shared types and constants for the cluster timer arbiter.
//               FSM state encoding, the data word returned on a response
//               timeout, and a helper that sizes requester index fields.
// Revision    : 1.0 - initial release
// ============================================================================
package cluster_timer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Read data returned to the requester when the timer never answers.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hBADC_0DE5;

    // Width of an index into n requesters. Never returns 0, so a
    // one-requester build still has a legal 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cluster_timer_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : cluster_timer_rr_arb
// Description : Combinational round-robin priority search. Returns the first
//               set request bit found by scanning from ptr upward and
//               wrapping modulo NB_MASTERS.
// Ports       : req    - request vector, one bit per requester
//               ptr    - index holding the highest priority this round
//               valid  - at least one request is set
//               winner - index of the selected requester (0 when !valid)
// Revision    : 1.0 - initial release
// ============================================================================
module cluster_timer_rr_arb
    import cluster_timer_arb_pkg::*;
#(
    parameter int NB_MASTERS = 4,
    parameter int IDX_W      = idx_width(NB_MASTERS)
) (
    input  logic [NB_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic                  valid,
    output logic [IDX_W-1:0]      winner
);

    int w_pos;

    // Scan from the farthest offset down to offset 0 so the closest set bit
    // to ptr is the last one written and therefore wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_pos  = 0;
        for (int i = NB_MASTERS - 1; i >= 0; i--) begin
            w_pos = int'(ptr) + i;
            if (w_pos >= NB_MASTERS) begin
                w_pos = w_pos - NB_MASTERS;
            end
            if (req[w_pos]) begin
                valid  = 1'b1;
                winner = IDX_W'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cluster_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cluster_timer_arbiter
// Description : Round-robin arbiter sharing one cluster timer slave port
//               between NB_MASTERS requesters on the req/gnt/r_valid
//               peripheral bus. One transaction in flight at a time; a
//               response timeout returns an error word so a hung timer
//               cannot deadlock the requesters.
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               m_*                    - requester side (gnt/r_valid one-hot,
//                                        rdata/opc shared)
//               s_*                    - timer slave side
//               busy_o                 - a transaction is in flight
//               timeout_o              - one-cycle pulse on a timeout
// Revision    : 1.0 - initial release
// ============================================================================
module cluster_timer_arbiter
    import cluster_timer_arb_pkg::*;
#(
    parameter int NB_MASTERS     = 4,
    parameter int ID_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NB_MASTERS-1:0]      m_req_i,
    input  logic [NB_MASTERS-1:0][31:0] m_add_i,
    input  logic [NB_MASTERS-1:0]      m_we_n_i,
    input  logic [NB_MASTERS-1:0][31:0] m_wdata_i,
    input  logic [NB_MASTERS-1:0][3:0] m_be_i,
    output logic [NB_MASTERS-1:0]      m_gnt_o,
    output logic [NB_MASTERS-1:0]      m_r_valid_o,
    output logic [31:0]                m_r_rdata_o,
    output logic                       m_r_opc_o,
    output logic                       s_req_o,
    output logic [31:0]                s_add_o,
    output logic                       s_we_n_o,
    output logic [31:0]                s_wdata_o,
    output logic [3:0]                 s_be_o,
    output logic [ID_WIDTH-1:0]        s_id_o,
    input  logic                       s_gnt_i,
    input  logic                       s_r_valid_i,
    input  logic [31:0]                s_r_rdata_i,
    input  logic                       s_r_opc_i,
    input  logic [ID_WIDTH-1:0]        s_r_id_i,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int IDX_W = idx_width(NB_MASTERS);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NB_MASTERS - 1);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_owner;
    logic [31:0]           r_add;
    logic                  r_we_n;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_arb_valid;
    logic [IDX_W-1:0]      w_arb_idx;
    logic                  w_capture;
    logic                  w_granted;
    logic [NB_MASTERS-1:0] w_owner_oh;
    logic                  w_resp_match;

    cluster_timer_rr_arb #(
        .NB_MASTERS (NB_MASTERS),
        .IDX_W      (IDX_W)
    ) u_rr_arb (
        .req    (m_req_i),
        .ptr    (r_ptr),
        .valid  (w_arb_valid),
        .winner (w_arb_idx)
    );

    assign w_owner_oh   = NB_MASTERS'(1) << r_owner;
    assign w_resp_match = s_r_valid_i && (s_r_id_i == s_id_o);

    // The slave side is always driven from the capture registers; only
    // s_req_o qualifies it, so no extra muxing is needed.
    assign s_add_o   = r_add;
    assign s_we_n_o  = r_we_n;
    assign s_wdata_o = r_wdata;
    assign s_be_o    = r_be;
    assign s_id_o    = ID_WIDTH'(r_owner);
    assign busy_o    = (r_state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_add   <= '0;
            r_we_n  <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_owner <= w_arb_idx;
                r_add   <= m_add_i[w_arb_idx];
                r_we_n  <= m_we_n_i[w_arb_idx];
                r_wdata <= m_wdata_i[w_arb_idx];
                r_be    <= m_be_i[w_arb_idx];
            end
            if (w_granted) begin
                // Priority moves just past the requester being served.
                r_ptr <= (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;
                r_cnt <= '0;
            end else if (r_state == RESP) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_granted   = 1'b0;
        s_req_o     = 1'b0;
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        m_r_rdata_o = '0;
        m_r_opc_o   = 1'b0;
        timeout_o   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                s_req_o = 1'b1;
                if (s_gnt_i) begin
                    m_gnt_o     = w_owner_oh;
                    w_granted   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                // A real, matching response beats a timeout in the same cycle.
                if (w_resp_match) begin
                    m_r_valid_o = w_owner_oh;
                    m_r_rdata_o = s_r_rdata_i;
                    m_r_opc_o   = s_r_opc_i;
                    w_state_nxt = IDLE;
                end else if ((TIMEOUT_CYCLES > 0) && (r_cnt == c_cnt_last)) begin
                    m_r_valid_o = w_owner_oh;
                    m_r_rdata_o = TIMEOUT_RDATA;
                    m_r_opc_o   = 1'b1;
                    timeout_o   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cluster_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cluster_timer_arbiter
// Description : Self-checking bench for cluster_timer_arbiter (4 requesters,
//               timeout of 8 cycles). Vector table for the single read,
//               stray and mismatched responses; directed sequences for
//               round-robin order, timeout, timeout coincidence and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cluster_timer_arbiter;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [3:0]       m_req_i;
    logic [3:0][31:0] m_add_i;
    logic [3:0]       m_we_n_i;
    logic [3:0][31:0] m_wdata_i;
    logic [3:0][3:0]  m_be_i;
    logic [3:0]       m_gnt_o;
    logic [3:0]       m_r_valid_o;
    logic [31:0]      m_r_rdata_o;
    logic             m_r_opc_o;
    logic             s_req_o;
    logic [31:0]      s_add_o;
    logic             s_we_n_o;
    logic [31:0]      s_wdata_o;
    logic [3:0]       s_be_o;
    logic [1:0]       s_id_o;
    logic             s_gnt_i;
    logic             s_r_valid_i;
    logic [31:0]      s_r_rdata_i;
    logic             s_r_opc_i;
    logic [1:0]       s_r_id_i;
    logic             busy_o;
    logic             timeout_o;

    int n_checks = 0;
    int n_err    = 0;

    cluster_timer_arbiter #(
        .NB_MASTERS     (4),
        .ID_WIDTH       (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .m_req_i     (m_req_i),
        .m_add_i     (m_add_i),
        .m_we_n_i    (m_we_n_i),
        .m_wdata_i   (m_wdata_i),
        .m_be_i      (m_be_i),
        .m_gnt_o     (m_gnt_o),
        .m_r_valid_o (m_r_valid_o),
        .m_r_rdata_o (m_r_rdata_o),
        .m_r_opc_o   (m_r_opc_o),
        .s_req_o     (s_req_o),
        .s_add_o     (s_add_o),
        .s_we_n_o    (s_we_n_o),
        .s_wdata_o   (s_wdata_o),
        .s_be_o      (s_be_o),
        .s_id_o      (s_id_o),
        .s_gnt_i     (s_gnt_i),
        .s_r_valid_i (s_r_valid_i),
        .s_r_rdata_i (s_r_rdata_i),
        .s_r_opc_i   (s_r_opc_i),
        .s_r_id_i    (s_r_id_i),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        opc;
        logic [1:0]  rid;
        logic [3:0]  e_gnt;
        logic [3:0]  e_rv;
        logic [31:0] e_rdata;
        logic        e_opc;
        logic        e_sreq;
        logic [1:0]  e_sid;
        logic        e_busy;
        logic        e_to;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] outs();
        return 96'({m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
                    s_req_o, s_id_o, busy_o, timeout_o});
    endfunction

    // Waits for a grant, at most 10 cycles; s_r_valid_i is low meanwhile.
    task automatic wait_gnt(output bit seen);
        int waited = 0;
        while (m_gnt_o == 4'b0000 && waited < 10) begin
            @(negedge clk);
            s_r_valid_i = 1'b0;
            #1;
            waited++;
        end
        seen = (m_gnt_o != 4'b0000);
    endtask

    initial begin
        bit         seen;
        bit         early;
        logic [1:0] exp_owner;

        // Per-requester payload.
        m_add_i[0] = 32'h1A10_A000;  m_wdata_i[0] = 32'hD000_0000;  m_be_i[0] = 4'b0001;
        m_add_i[1] = 32'h1A10_A100;  m_wdata_i[1] = 32'hD000_0001;  m_be_i[1] = 4'b0011;
        m_add_i[2] = 32'h1A10_B004;  m_wdata_i[2] = 32'hD000_0002;  m_be_i[2] = 4'b0111;
        m_add_i[3] = 32'h1A10_A300;  m_wdata_i[3] = 32'hD000_0003;  m_be_i[3] = 4'b1111;
        m_we_n_i   = 4'b0101;

        //          name          req      gnt   rv    rdata          opc   rid    e_gnt    e_rv     e_rdata        e_opc e_sreq e_sid  e_busy e_to
        vecs[0]  = '{"rd_capture", 4'b0100, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0,  4'b0000, 4'b0000, 32'h0,         1'b0, 1'b0,  2'd0,  1'b0,  1'b0};
        vecs[1]  = '{"rd_req1",    4'b0100, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0,  4'b0000, 4'b0000, 32'h0,         1'b0, 1'b1,  2'd2,  1'b1,  1'b0};
        vecs[2]  = '{"rd_req2",    4'b0100, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0,  4'b0000, 4'b0000, 32'h0,         1'b0, 1'b1,  2'd2,  1'b1,  1'b0};
        vecs[3]  = '{"rd_gnt",     4'b0100, 1'b1, 1'b0, 32'h0,         1'b0, 2'd0,  4'b0100, 4'b0000, 32'h0,         1'b0, 1'b1,  2'd2,  1'b1,  1'b0};
        vecs[4]  = '{"rd_resp",    4'b0000, 1'b0, 1'b1, 32'h1234,      1'b0, 2'd2,  4'b0000, 4'b0100, 32'h1234,      1'b0, 1'b0,  2'd2,  1'b1,  1'b0};
        vecs[5]  = '{"rd_idle",    4'b0000, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0,  4'b0000, 4'b0000, 32'h0,         1'b0, 1'b0,  2'd2,  1'b0,  1'b0};
        vecs[6]  = '{"stray_idle", 4'b0000, 1'b0, 1'b1, 32'hDEAD,      1'b1, 2'd2,  4'b0000, 4'b0000, 32'h0,         1'b0, 1'b0,  2'd2,  1'b0,  1'b0};
        vecs[7]  = '{"id_capture", 4'b0001, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0,  4'b0000, 4'b0000, 32'h0,         1'b0, 1'b0,  2'd2,  1'b0,  1'b0};
        vecs[8]  = '{"id_gnt",     4'b0001, 1'b1, 1'b0, 32'h0,         1'b0, 2'd0,  4'b0001, 4'b0000, 32'h0,         1'b0, 1'b1,  2'd0,  1'b1,  1'b0};
        vecs[9]  = '{"id_wrong",   4'b0000, 1'b0, 1'b1, 32'hAAAA,      1'b0, 2'd1,  4'b0000, 4'b0000, 32'h0,         1'b0, 1'b0,  2'd0,  1'b1,  1'b0};
        vecs[10] = '{"id_wait",    4'b0000, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0,  4'b0000, 4'b0000, 32'h0,         1'b0, 1'b0,  2'd0,  1'b1,  1'b0};
        vecs[11] = '{"id_match",   4'b0000, 1'b0, 1'b1, 32'h00C0_FFEE, 1'b1, 2'd0,  4'b0000, 4'b0001, 32'h00C0_FFEE, 1'b1, 1'b0,  2'd0,  1'b1,  1'b0};
        vecs[12] = '{"id_idle",    4'b0000, 1'b0, 1'b0, 32'h0,         1'b0, 2'd0,  4'b0000, 4'b0000, 32'h0,         1'b0, 1'b0,  2'd0,  1'b0,  1'b0};

        rst_ni      = 1'b0;
        m_req_i     = 4'b0000;
        s_gnt_i     = 1'b0;
        s_r_valid_i = 1'b0;
        s_r_rdata_i = 32'h0;
        s_r_opc_i   = 1'b0;
        s_r_id_i    = 2'd0;

        #2;
        chk("reset_outputs", outs(), 96'h0);
        chk("reset_payload", 96'({s_add_o, s_we_n_o, s_wdata_o, s_be_o}), 96'h0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            m_req_i     = vecs[i].req;
            s_gnt_i     = vecs[i].gnt;
            s_r_valid_i = vecs[i].rv;
            s_r_rdata_i = vecs[i].rdata;
            s_r_opc_i   = vecs[i].opc;
            s_r_id_i    = vecs[i].rid;
            #1;
            chk(vecs[i].name, outs(),
                96'({vecs[i].e_gnt, vecs[i].e_rv, vecs[i].e_rdata, vecs[i].e_opc,
                     vecs[i].e_sreq, vecs[i].e_sid, vecs[i].e_busy, vecs[i].e_to}));
            if (vecs[i].e_sreq) begin
                chk({vecs[i].name, "_payload"},
                    96'({s_add_o, s_we_n_o, s_wdata_o, s_be_o}),
                    96'({m_add_i[vecs[i].e_sid], m_we_n_i[vecs[i].e_sid],
                         m_wdata_i[vecs[i].e_sid], m_be_i[vecs[i].e_sid]}));
            end
        end

        // ---------------- round robin from a fresh reset ----------------
        @(negedge clk);
        m_req_i = 4'b0000; s_gnt_i = 1'b0; s_r_valid_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni  = 1'b1;
        m_req_i = 4'b1111;
        s_gnt_i = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_owner = 2'(k % 4);
            wait_gnt(seen);
            chk("rr_gnt", 96'(m_gnt_o), 96'(4'b0001 << exp_owner));
            @(negedge clk);
            s_r_valid_i = 1'b1;
            s_r_id_i    = exp_owner;
            s_r_rdata_i = 32'(k);
            #1;
            chk("rr_rvalid", 96'({m_r_valid_o, m_r_rdata_o}),
                96'({4'b0001 << exp_owner, 32'(k)}));
        end
        // IDLE cycle follows; drop requests before it can capture.
        @(negedge clk);
        m_req_i = 4'b0000; s_r_valid_i = 1'b0; s_gnt_i = 1'b0;
        #1;
        chk("rr_done_idle", 96'(busy_o), 96'(1'b0));

        // ---------------- timeout (pointer now 1) ----------------
        @(negedge clk);
        m_req_i = 4'b0010;
        @(negedge clk);
        s_gnt_i = 1'b1;
        #1;
        chk("to_gnt", 96'(m_gnt_o), 96'(4'b0010));
        early = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            s_gnt_i = 1'b0;
            m_req_i = 4'b0000;
            #1;
            if (c < 8) begin
                if (m_r_valid_o != 4'b0000 || timeout_o) early = 1'b1;
            end else begin
                chk("to_no_early", 96'(early), 96'(1'b0));
                chk("to_fire", 96'({m_r_valid_o, m_r_rdata_o, m_r_opc_o, timeout_o}),
                    96'({4'b0010, 32'hBADC_0DE5, 1'b1, 1'b1}));
            end
        end
        @(negedge clk);
        s_r_valid_i = 1'b1; s_r_id_i = 2'd1; s_r_rdata_i = 32'h77; s_r_opc_i = 1'b0;
        #1;
        chk("to_late_drop", outs(), 96'({4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0}));

        // ---------------- response on the exact timeout cycle ----------------
        @(negedge clk);
        s_r_valid_i = 1'b0;
        m_req_i = 4'b0100;
        @(negedge clk);
        s_gnt_i = 1'b1;
        #1;
        chk("co_gnt", 96'(m_gnt_o), 96'(4'b0100));
        early = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            s_gnt_i = 1'b0;
            m_req_i = 4'b0000;
            #1;
            if (m_r_valid_o != 4'b0000 || timeout_o) early = 1'b1;
        end
        chk("co_no_early", 96'(early), 96'(1'b0));
        @(negedge clk);
        s_r_valid_i = 1'b1; s_r_id_i = 2'd2; s_r_rdata_i = 32'h55; s_r_opc_i = 1'b0;
        #1;
        chk("co_real_wins", 96'({m_r_valid_o, m_r_rdata_o, m_r_opc_o, timeout_o}),
            96'({4'b0100, 32'h55, 1'b0, 1'b0}));

        // ---------------- reset in REQ with pointer at 3 ----------------
        @(negedge clk);
        s_r_valid_i = 1'b0;
        m_req_i = 4'b1111;
        @(negedge clk);
        #1;
        chk("rst_pre_req", 96'({s_req_o, s_id_o}), 96'({1'b1, 2'd3}));
        s_gnt_i = 1'b1;
        #1;
        chk("rst_pre_gnt", 96'(m_gnt_o), 96'(4'b1000));
        rst_ni = 1'b0;
        #1;
        chk("rst_async", 96'({s_req_o, busy_o, m_gnt_o}), 96'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        wait_gnt(seen);
        chk("rst_first_gnt", 96'(m_gnt_o), 96'(4'b0001));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
